// File: rtl/lsz_decode_pkg.sv
// rtl/lsz_decode_pkg.sv - shared widths and decoder state type for the LSZ decode path
package lsz_decode_pkg;

  localparam int INWD_DEF    = 8;
  localparam int LOGINWD_DEF = 3;

  typedef enum logic {
    TRACK = 1'b0,
    ERR   = 1'b1
  } lsz_state_e;

endpackage

// File: rtl/lsz_decode_lsz.sv
// rtl/lsz_decode_lsz.sv - index of the least significant zero bit of a count
module lsz_decode_lsz
  import lsz_decode_pkg::*;
#(
  parameter int INWD    = INWD_DEF,
  parameter int LOGINWD = LOGINWD_DEF
) (
  input  logic [INWD-1:0]    in,
  output logic [LOGINWD-1:0] lszidx
);

  // Scan MSB down so the lowest zero wins; an all-ones input yields 0 and is overridden by the caller.
  always_comb begin
    lszidx = '0;
    for (int i = INWD - 1; i >= 0; i--) begin
      if (!in[i]) lszidx = LOGINWD'(i);
    end
  end

endmodule

// File: rtl/lsz_decode.sv
// rtl/lsz_decode.sv - rebuilds Sobol step count and Gray state from a checked LSZ index stream
module lsz_decode
  import lsz_decode_pkg::*;
#(
  parameter int INWD    = INWD_DEF,
  parameter int LOGINWD = LOGINWD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LOGINWD-1:0] lszidx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INWD-1:0]    cnt,
  output logic [INWD-1:0]    gray,
  output logic               err
);

  lsz_state_e          state_q, state_d;
  logic [INWD-1:0]     n_q, n_d;
  logic [INWD-1:0]     gray_r_q, gray_r_d;
  logic [INWD-1:0]     cnt_q, cnt_d;
  logic [INWD-1:0]     gray_o_q, gray_o_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic [LOGINWD-1:0]  lsz_raw;
  logic [LOGINWD-1:0]  expected;
  logic                accept;

  lsz_decode_lsz #(
    .INWD    (INWD),
    .LOGINWD (LOGINWD)
  ) u_lsz (
    .in     (n_q),
    .lszidx (lsz_raw)
  );

  // All-ones count has no zero bit; the wrap step toggles the MSB.
  assign expected = (&n_q) ? LOGINWD'(INWD - 1) : lsz_raw;

  assign in_ready = (state_q == TRACK) ? (!out_valid_q || out_ready) : 1'b1;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TRACK;
      n_q         <= '0;
      gray_r_q    <= '0;
      cnt_q       <= '0;
      gray_o_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      gray_r_q    <= gray_r_d;
      cnt_q       <= cnt_d;
      gray_o_q    <= gray_o_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    gray_r_d    = gray_r_q;
    cnt_d       = cnt_q;
    gray_o_d    = gray_o_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      state_d     = TRACK;
      n_d         = '0;
      gray_r_d    = '0;
      cnt_d       = '0;
      gray_o_d    = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        TRACK: begin
          if (accept) begin
            if (lszidx == expected) begin
              n_d         = n_q + INWD'(1);
              gray_r_d    = gray_r_q ^ (INWD'(1) << lszidx);
              cnt_d       = n_d;
              gray_o_d    = gray_r_d;
              out_valid_d = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
        ERR: begin
          // Inputs are drained and dropped until resync.
        end
        default: state_d = TRACK;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign cnt       = cnt_q;
  assign gray      = gray_o_q;
  assign err       = err_q;

endmodule
